// File: rtl/tank_pkg.sv
// ============================================================================
//  Module      : tank_pkg
//  Description : Shared encodings and field geometry for the tank controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tank_pkg;

  localparam int FIELD_W   = 640;
  localparam int FIELD_H   = 480;
  localparam int SPRITE_SZ = 16;
  localparam int POS_X_W   = 10;
  localparam int POS_Y_W   = 9;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    F_READY = 2'd0,
    F_REQ   = 2'd1,
    F_COOL  = 2'd2
  } fire_state_t;

  // Muzzle sits at the sprite centre.
  function automatic int muzzle_off();
    return SPRITE_SZ / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tank_fire_ctrl.sv
// ============================================================================
//  Module      : tank_fire_ctrl
//  Description : Fire-request FSM with cooldown counter and muzzle latch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tank_fire_ctrl
  import tank_pkg::*;
#(
  parameter int COOLDOWN = 16
) (
  input  logic               clk,
  input  logic               RSTn,
  input  logic               zhen,
  input  logic               key_fire,
  input  logic               fire_ack,
  input  logic [POS_X_W-1:0] pos_x,
  input  logic [POS_Y_W-1:0] pos_y,
  output logic               fire_req,
  output logic [POS_X_W-1:0] fire_x,
  output logic [POS_Y_W-1:0] fire_y
);

  localparam logic [7:0]         c_cooldown = COOLDOWN[7:0];
  localparam logic [POS_X_W-1:0] c_off_x    = POS_X_W'(muzzle_off());
  localparam logic [POS_Y_W-1:0] c_off_y    = POS_Y_W'(muzzle_off());

  fire_state_t r_state;
  logic [7:0]  r_cool_cnt;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= F_READY;
      r_cool_cnt <= 8'd0;
      fire_req   <= 1'b0;
      fire_x     <= '0;
      fire_y     <= '0;
    end else begin
      case (r_state)
        F_READY: begin
          if (zhen && key_fire) begin
            r_state  <= F_REQ;
            fire_req <= 1'b1;
            fire_x   <= pos_x + c_off_x;
            fire_y   <= pos_y + c_off_y;
          end
        end
        // Ack wins over a coincident tick: the counter loads without decrementing.
        F_REQ: begin
          if (fire_ack) begin
            r_state    <= F_COOL;
            fire_req   <= 1'b0;
            r_cool_cnt <= c_cooldown;
          end
        end
        F_COOL: begin
          if (zhen) begin
            r_cool_cnt <= r_cool_cnt - 8'd1;
            if (r_cool_cnt == 8'd1) r_state <= F_READY;
          end
        end
        default: r_state <= F_READY;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/tank_motion_ctrl.sv
// ============================================================================
//  Module      : tank_motion_ctrl
//  Description : Per-frame tank motion, facing and fire-request controller.
//                TANK_MOTION_WRAP_EN: wrap at field edges instead of clamping.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tank_motion_ctrl
  import tank_pkg::*;
#(
  parameter int X_MAX    = FIELD_W - SPRITE_SZ,
  parameter int Y_MAX    = FIELD_H - SPRITE_SZ,
  parameter int X_INIT   = 304,
  parameter int Y_INIT   = 440,
  parameter int STEP     = 2,
  parameter int COOLDOWN = 16
) (
  input  logic               clk,
  input  logic               RSTn,
  input  logic               zhen,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               key_fire,
  input  logic               fire_ack,
  output logic [POS_X_W-1:0] pos_x,
  output logic [POS_Y_W-1:0] pos_y,
  output logic [1:0]         dir,
  output logic               moving,
  output logic               fire_req,
  output logic [POS_X_W-1:0] fire_x,
  output logic [POS_Y_W-1:0] fire_y
);

  localparam logic [POS_X_W:0]   c_x_max  = X_MAX[POS_X_W:0];
  localparam logic [POS_Y_W:0]   c_y_max  = Y_MAX[POS_Y_W:0];
  localparam logic [POS_X_W:0]   c_step_x = STEP[POS_X_W:0];
  localparam logic [POS_Y_W:0]   c_step_y = STEP[POS_Y_W:0];
  localparam logic [POS_X_W-1:0] c_x_init = X_INIT[POS_X_W-1:0];
  localparam logic [POS_Y_W-1:0] c_y_init = Y_INIT[POS_Y_W-1:0];
`ifdef TANK_MOTION_WRAP_EN
  localparam logic [POS_X_W-1:0] c_x_under = X_MAX[POS_X_W-1:0];
  localparam logic [POS_X_W-1:0] c_x_over  = '0;
  localparam logic [POS_Y_W-1:0] c_y_under = Y_MAX[POS_Y_W-1:0];
  localparam logic [POS_Y_W-1:0] c_y_over  = '0;
`else
  localparam logic [POS_X_W-1:0] c_x_under = '0;
  localparam logic [POS_X_W-1:0] c_x_over  = X_MAX[POS_X_W-1:0];
  localparam logic [POS_Y_W-1:0] c_y_under = '0;
  localparam logic [POS_Y_W-1:0] c_y_over  = Y_MAX[POS_Y_W-1:0];
`endif

  logic               w_key_any;
  logic [1:0]         w_dir;
  logic [POS_X_W:0]   w_x_inc, w_x_dec;
  logic [POS_Y_W:0]   w_y_inc, w_y_dec;
  logic [POS_X_W-1:0] w_x_next;
  logic [POS_Y_W-1:0] w_y_next;
  logic               w_moving;

  assign w_key_any = key_up | key_down | key_left | key_right;

  always_comb begin
    w_dir = dir;
    if      (key_up)    w_dir = DIR_UP;
    else if (key_down)  w_dir = DIR_DOWN;
    else if (key_left)  w_dir = DIR_LEFT;
    else if (key_right) w_dir = DIR_RIGHT;
  end

  // One extra bit: MSB of a decrement flags underflow, increments compare to max.
  assign w_x_inc = {1'b0, pos_x} + c_step_x;
  assign w_x_dec = {1'b0, pos_x} - c_step_x;
  assign w_y_inc = {1'b0, pos_y} + c_step_y;
  assign w_y_dec = {1'b0, pos_y} - c_step_y;

  always_comb begin
    w_x_next = pos_x;
    w_y_next = pos_y;
    if (w_key_any) begin
      case (w_dir)
        DIR_UP:    w_y_next = w_y_dec[POS_Y_W] ? c_y_under : w_y_dec[POS_Y_W-1:0];
        DIR_DOWN:  w_y_next = (w_y_inc > c_y_max) ? c_y_over : w_y_inc[POS_Y_W-1:0];
        DIR_LEFT:  w_x_next = w_x_dec[POS_X_W] ? c_x_under : w_x_dec[POS_X_W-1:0];
        DIR_RIGHT: w_x_next = (w_x_inc > c_x_max) ? c_x_over : w_x_inc[POS_X_W-1:0];
      endcase
    end
  end

`ifdef TANK_MOTION_WRAP_EN
  assign w_moving = w_key_any;
`else
  assign w_moving = (w_x_next != pos_x) || (w_y_next != pos_y);
`endif

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      pos_x  <= c_x_init;
      pos_y  <= c_y_init;
      dir    <= DIR_UP;
      moving <= 1'b0;
    end else if (zhen) begin
      pos_x  <= w_x_next;
      pos_y  <= w_y_next;
      dir    <= w_dir;
      moving <= w_moving;
    end
  end

  // Fire path sees pre-update coordinates so the muzzle matches the drawn sprite.
  tank_fire_ctrl #(
    .COOLDOWN (COOLDOWN)
  ) u_fire (
    .clk      (clk),
    .RSTn     (RSTn),
    .zhen     (zhen),
    .key_fire (key_fire),
    .fire_ack (fire_ack),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .fire_req (fire_req),
    .fire_x   (fire_x),
    .fire_y   (fire_y)
  );

endmodule

`default_nettype wire

// File: tb/tb_tank_motion_ctrl.sv
// ============================================================================
//  Module      : tb_tank_motion_ctrl
//  Description : Directed scoreboard bench for tank_motion_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tank_motion_ctrl;

  localparam int X_MAX    = 624;
  localparam int Y_MAX    = 464;
  localparam int X_INIT   = 304;
  localparam int Y_INIT   = 440;
  localparam int STEP     = 2;
  localparam int COOLDOWN = 16;
`ifdef TANK_MOTION_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       RSTn = 1'b1;
  logic       zhen = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       key_fire = 1'b0, fire_ack = 1'b0;
  logic [9:0] pos_x, fire_x;
  logic [8:0] pos_y, fire_y;
  logic [1:0] dir;
  logic       moving, fire_req;

  tank_motion_ctrl #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_INIT(X_INIT), .Y_INIT(Y_INIT),
    .STEP(STEP), .COOLDOWN(COOLDOWN)
  ) dut (
    .clk(clk), .RSTn(RSTn), .zhen(zhen),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .key_fire(key_fire), .fire_ack(fire_ack),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moving(moving),
    .fire_req(fire_req), .fire_x(fire_x), .fire_y(fire_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int y; int d; int mov; int req; int fx; int fy;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_total = 0;

  int m_x, m_y, m_dir, m_mov, m_req, m_fx, m_fy, m_st, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic model_reset();
    m_x = X_INIT; m_y = Y_INIT; m_dir = 0; m_mov = 0;
    m_req = 0; m_fx = 0; m_fy = 0; m_st = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit z, input bit u, input bit d, input bit l,
                            input bit r, input bit f, input bit a);
    int nx, ny;
    case (m_st)
      0: if (z && f) begin m_req = 1; m_fx = m_x + 8; m_fy = m_y + 8; m_st = 1; end
      1: if (a) begin m_req = 0; m_cnt = COOLDOWN; m_st = 2; end
      default: if (z) begin m_cnt--; if (m_cnt == 0) m_st = 0; end
    endcase
    if (z) begin
      if (u || d || l || r) begin
        m_dir = u ? 0 : d ? 1 : l ? 2 : 3;
        nx = m_x; ny = m_y;
        case (m_dir)
          0: ny = m_y - STEP;
          1: ny = m_y + STEP;
          2: nx = m_x - STEP;
          default: nx = m_x + STEP;
        endcase
        if (nx < 0)     nx = WRAP ? X_MAX : 0;
        if (nx > X_MAX) nx = WRAP ? 0 : X_MAX;
        if (ny < 0)     ny = WRAP ? Y_MAX : 0;
        if (ny > Y_MAX) ny = WRAP ? 0 : Y_MAX;
        m_mov = WRAP ? 1 : ((nx != m_x) || (ny != m_y)) ? 1 : 0;
        m_x = nx; m_y = ny;
      end else begin
        m_mov = 0;
      end
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.x = m_x; e.y = m_y; e.d = m_dir; e.mov = m_mov;
    e.req = m_req; e.fx = m_fx; e.fy = m_fy;
    return e;
  endfunction

  task automatic compare_pop(input string tag);
    exp_t e;
    n_total++;
    assert (q.size() > 0) n_pass++;
    else $error("FAIL %s_queue: observed %0d expected %0d", tag, q.size(), 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_x"},   32'(pos_x),    e.x);
      chk({tag, "_y"},   32'(pos_y),    e.y);
      chk({tag, "_dir"}, 32'(dir),      e.d);
      chk({tag, "_mov"}, 32'(moving),   e.mov);
      chk({tag, "_req"}, 32'(fire_req), e.req);
      chk({tag, "_fx"},  32'(fire_x),   e.fx);
      chk({tag, "_fy"},  32'(fire_y),   e.fy);
    end
  endtask

  task automatic cycle(input string tag, input bit z, input bit u, input bit d,
                       input bit l, input bit r, input bit f, input bit a);
    @(negedge clk);
    zhen = z; key_up = u; key_down = d; key_left = l; key_right = r;
    key_fire = f; fire_ack = a;
    model_step(z, u, d, l, r, f, a);
    q.push_back(snap());
    @(posedge clk);
    #1;
    zhen = 1'b0; fire_ack = 1'b0;
    compare_pop(tag);
  endtask

  // A frame tick followed by a quiet cycle where keys must be ignored.
  task automatic tick(input string tag, input bit u, input bit d, input bit l,
                      input bit r, input bit f, input bit a);
    cycle(tag, 1'b1, u, d, l, r, f, a);
    cycle({tag, "_gap"}, 1'b0, ~u, ~d, ~l, ~r, ~f, 1'b0);
  endtask

  initial begin
    model_reset();
    #2 RSTn = 1'b0;
    #1;
    chk("rst_x", 32'(pos_x), X_INIT);
    chk("rst_y", 32'(pos_y), Y_INIT);
    chk("rst_req", 32'(fire_req), 0);
    repeat (2) @(negedge clk);
    RSTn = 1'b1;

    for (int i = 0; i < 5; i++) tick("idle", 0, 0, 0, 0, 0, 0);
    chk("idle_pos_x", 32'(pos_x), 304);
    chk("idle_pos_y", 32'(pos_y), 440);

    tick("right1", 0, 0, 0, 1, 0, 0);
    chk("right1_x", 32'(pos_x), 306);
    tick("right2", 0, 0, 0, 1, 0, 0);
    chk("right2_x", 32'(pos_x), 308);
    tick("right3", 0, 0, 0, 1, 0, 0);
    chk("right3_x", 32'(pos_x), 310);
    chk("right3_dir", 32'(dir), 3);
    chk("right3_mov", 32'(moving), 1);

    for (int i = 0; i < 3; i++) tick("upleft", 1, 0, 1, 0, 0, 0);
    chk("upleft_x", 32'(pos_x), 310);
    chk("upleft_y", 32'(pos_y), 434);
    chk("upleft_dir", 32'(dir), 0);

    while (m_x > 2) tick("to_left", 0, 0, 1, 0, 0, 0);
    tick("left_edge", 0, 0, 1, 0, 0, 0);
    chk("left_edge_x", 32'(pos_x), 0);
    chk("left_edge_mov", 32'(moving), 1);
    tick("left_past", 0, 0, 1, 0, 0, 0);
    chk("left_past_x", 32'(pos_x), WRAP ? 624 : 0);
    chk("left_past_mov", 32'(moving), WRAP ? 1 : 0);
    chk("left_past_dir", 32'(dir), 2);

    while (m_x < X_MAX) tick("to_right", 0, 0, 0, 1, 0, 0);
    tick("right_past", 0, 0, 0, 1, 0, 0);
    chk("right_past_x", 32'(pos_x), WRAP ? 0 : 624);

    while (m_x > 100) tick("nav", 0, 0, 1, 0, 0, 0);
    while (m_x < 100) tick("nav", 0, 0, 0, 1, 0, 0);
    while (m_y > 200) tick("nav", 1, 0, 0, 0, 0, 0);
    while (m_y < 200) tick("nav", 0, 1, 0, 0, 0, 0);

    tick("fire", 0, 0, 0, 1, 1, 0);
    chk("fire_req", 32'(fire_req), 1);
    chk("fire_x", 32'(fire_x), 108);
    chk("fire_y", 32'(fire_y), 208);
    for (int i = 0; i < 3; i++) tick("fire_hold", 0, 0, 0, 1, 1, 0);
    chk("hold_fx", 32'(fire_x), 108);
    tick("ack_tick", 0, 1, 0, 0, 1, 1);
    chk("ack_req", 32'(fire_req), 0);
    for (int i = 0; i < 15; i++) tick("cool", 0, 0, 0, 0, 1, (i == 4));
    cycle("cool_ack", 1'b0, 0, 0, 0, 0, 1, 1);
    tick("cool_last", 0, 0, 0, 0, 1, 0);
    chk("cool16_req", 32'(fire_req), 0);
    tick("refire", 0, 0, 0, 0, 1, 0);
    chk("refire_req", 32'(fire_req), 1);

    cycle("ack_idle", 1'b0, 0, 0, 0, 0, 0, 1);
    chk("ack_idle_req", 32'(fire_req), 0);
    for (int i = 0; i < 16; i++) tick("cool2", 0, 0, 0, 0, 0, 0);
    tick("fire3", 0, 1, 0, 0, 1, 0);
    chk("fire3_req", 32'(fire_req), 1);

    @(negedge clk);
    #2 RSTn = 1'b0;
    #1;
    chk("async_rst_req", 32'(fire_req), 0);
    chk("async_rst_x", 32'(pos_x), X_INIT);
    chk("async_rst_fx", 32'(fire_x), 0);
    model_reset();
    @(negedge clk);
    RSTn = 1'b1;
    tick("post_rst", 0, 0, 0, 0, 0, 0);
    tick("post_rst_fire", 0, 0, 0, 0, 1, 0);
    chk("post_rst_fx", 32'(fire_x), X_INIT + 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tank_motion_ctrl.md
# tank_motion_ctrl

Per-frame tank motion and fire-request controller, directly downstream of the frame-tick generator. It consumes the single-cycle `zhen` frame pulse and synchronised key levels. On each tick it updates the tank's position and facing, and runs a fire-request FSM with cooldown. Outputs feed the sprite renderer (position, facing) and the bullet engine (fire request/ack handshake).

## Interface
- `X_MAX`, default 624: largest legal tank x (640-pixel field, 16-pixel sprite)
- `Y_MAX`, default 464: largest legal tank y
- `X_INIT`, default 304: x after reset
- `Y_INIT`, default 440: y after reset
- `STEP`, default 2: pixels moved per frame tick; must satisfy 1 ≤ STEP ≤ 15
- `COOLDOWN`, default 16: frame ticks between an acknowledged shot and the next request; 1..255

Ports:
- `clk` in 1: system clock
- `RSTn` in 1: asynchronous active-low reset
- `zhen` in 1: frame tick, one-cycle pulse
- `key_up`, `key_down`, `key_left`, `key_right` in 1 each: direction keys, level, already synchronised
- `key_fire` in 1: fire key, level
- `fire_ack` in 1: bullet engine accepted the request
- `pos_x` out 10: tank x, top-left
- `pos_y` out 9: tank y, top-left
- `dir` out 2: facing
  - 0 = up, 1 = down, 2 = left, 3 = right
- `moving` out 1: tank moved on the last tick
- `fire_req` out 1: shot request, held until acknowledged
- `fire_x` out 10, `fire_y` out 9: muzzle point latched with the request

## Operation
- **Key sampling:** keys are sampled only in cycles where `zhen`=1; key changes between ticks are ignored.
- **Direction priority:** up > down > left > right. The highest-priority pressed key sets `dir`, even if the move is blocked at the edge. With no key pressed, `dir` holds and `moving`=0.
- **Step:** the coordinate along `dir` changes by ±STEP. Up and left decrement; down and right increment.
- **Bounds (default, clamp):** the result saturates to [0, X_MAX] or [0, Y_MAX].
  - Arithmetic uses one extra bit to detect underflow or overflow.
  - `moving`=1 only if the coordinate actually changed.
- **Fire FSM:** states F_READY, F_REQ, F_COOL.
  - F_READY: on `zhen` with `key_fire`=1, go to F_REQ. In the same edge, set `fire_req`=1 and latch `fire_x`=`pos_x`+8 and `fire_y`=`pos_y`+8, using pre-update coordinates.
  - F_REQ: hold `fire_req`, `fire_x` and `fire_y` stable until `fire_ack`=1. On ack, clear `fire_req`, load `cool_cnt`=COOLDOWN and go to F_COOL. `zhen` pulses in F_REQ do not touch the FSM.
  - F_COOL: `cool_cnt` decrements on each `zhen`. On the tick where it reaches 0, go to F_READY.
  - Fire cannot be requested on the same tick the FSM enters F_READY.
- **Simultaneous `fire_ack` and `zhen`:** the ack is processed and `cool_cnt` loads COOLDOWN with no decrement that cycle. Motion still updates.
- **`fire_ack` outside F_REQ:** ignored.

## Timing
- All outputs are registered. They update on the rising edge where `zhen`=1 and are visible the following cycle (latency 1).
- Reset is asynchronous and takes effect immediately, including mid-request. Reset values:
  - `pos_x`=X_INIT, `pos_y`=Y_INIT
  - `dir`=0, `moving`=0
  - `fire_req`=0, `fire_x`=0, `fire_y`=0
  - FSM=F_READY, `cool_cnt`=0
- A pending request is dropped by reset with no ack required.
- `fire_ack` takes effect on the edge it is sampled high. `fire_req` is low the next cycle.
- Throughput: at most one move and one fire-FSM transition per frame tick, except the ack edge.

## Configuration
- `TANK_MOTION_WRAP_EN`, when defined: out-of-range steps wrap to the opposite edge instead of clamping.
  - Stepping left from x < STEP gives x = X_MAX.
  - Stepping right from x > X_MAX−STEP gives x = 0.
  - y behaves the same way.
  - `moving`=1 on every tick with a key pressed.
- When undefined: saturating clamp as specified in Operation.

## Structure
- Shared package `tank_pkg`:
  - direction encoding constants DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT
  - fire FSM state encoding
  - field dimensions (640×480, sprite 16)
  - position widths 10/9
- One sub-module, `tank_fire_ctrl`: holds the fire FSM, cooldown counter and muzzle latch. The motion datapath stays in the top.

## Test plan
- Reset release with no keys; 5 `zhen` pulses → `pos`=(304,440), `dir`=0, `moving`=0, `fire_req`=0.
- `key_right` held for 3 ticks from x=304 → `pos_x`=306, 308, 310, each one cycle after its tick; `dir`=3, `moving`=1.
- `key_up` and `key_left` held together → only y decrements by 2 per tick; `dir`=0.
- Clamp: x=1, `key_left`, one tick → x=0, `moving`=1. Next tick → x=0, `moving`=0, `dir`=2.
  - With WRAP_EN, the second tick gives x=624.
- Fire at `pos`=(100,200) → `fire_req`=1 with `fire_x`/`fire_y`=(108,208), held through 3 ticks without ack. Ack coincident with a `zhen` → `fire_req` drops and `cool_cnt`=16. Exactly 16 further ticks then pass before the next request.
- Assert `RSTn` low while `fire_req`=1 → `fire_req`=0 immediately, with no clock edge needed.
